// File: rtl/team_06_input_ctrl_if.sv
// Front-panel input bundle: raw pad inputs towards the controller, decoded
// button/volume results back out. Panel side uses master, controller uses slave.
interface team_06_input_ctrl_if #(
  parameter int NUM_BTN = 4,
  parameter int VOL_W   = 4
);
  // No valid/ready here: levels are held, and every *_rise/_hold/vol_*/enc_err
  // output is a single-cycle pulse that the consumer must sample every cycle.
  logic [NUM_BTN-1:0] pbs;
  logic [1:0]         enc_ab;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_state;
  logic [NUM_BTN-1:0] btn_hold;
  logic [VOL_W-1:0]   volume;
  logic               vol_up;
  logic               vol_dn;
  logic               enc_err;
  logic               enc_tracking;

  modport master (
    output pbs, enc_ab,
    input  btn_level, btn_rise, btn_state, btn_hold,
    input  volume, vol_up, vol_dn, enc_err, enc_tracking
  );

  modport slave (
    input  pbs, enc_ab,
    output btn_level, btn_rise, btn_state, btn_hold,
    output volume, vol_up, vol_dn, enc_err, enc_tracking
  );
endinterface

// File: rtl/team_06_input_ctrl.sv
// Pushbutton debounce/toggle and quadrature volume decoder for the front panel.
// Optional long-press detection is built only when INPUT_HOLD_EN is defined.
module team_06_input_ctrl #(
  parameter int                 NUM_BTN     = 4,
  parameter int                 DB_CYCLES   = 5000,
  parameter logic [NUM_BTN-1:0] TOGGLE_MASK = 4'b1110,
  parameter int                 VOL_W       = 4,
  parameter int                 VOL_INIT    = 0,
  parameter int                 HOLD_CYCLES = 25000000
) (
  input logic                  clk,
  input logic                  rst_n,
  team_06_input_ctrl_if.slave  bus
);

  localparam int                 DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [VOL_W-1:0]   VOL_MAX = {VOL_W{1'b1}};
  localparam logic [VOL_W-1:0]   VOL_RST = VOL_W'(VOL_INIT);

  typedef enum logic {ENC_PRIME, ENC_TRACK} enc_state_e;

  logic [NUM_BTN-1:0] pbs_meta_q, pbs_sync_q;
  logic [1:0]         enc_meta_q, enc_sync_q;
  logic [1:0]         sync_fill_q, sync_fill_d;

  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d, rise_q, rise_d, state_q, state_d;

  enc_state_e         enc_state_q, enc_state_d;
  logic [1:0]         prev_q, prev_d;
  logic [1:0]         pos_prev, pos_cur;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic               up_q, up_d, dn_q, dn_d, err_q, err_d;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (pbs_sync_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) level_d[i] = pbs_sync_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    rise_d  = level_d & ~level_q;
    state_d = (TOGGLE_MASK & (state_q ^ rise_d)) | (~TOGGLE_MASK & level_d);
  end

  // Gray code mapped to a 2-bit position so CW is +1 and ACW is -1 (mod 4).
  assign pos_prev = {prev_q[1], ^prev_q};
  assign pos_cur  = {enc_sync_q[1], ^enc_sync_q};

  always_comb begin
    enc_state_d = enc_state_q;
    prev_d      = prev_q;
    vol_d       = vol_q;
    up_d        = 1'b0;
    dn_d        = 1'b0;
    err_d       = 1'b0;
    sync_fill_d = {sync_fill_q[0], 1'b1};
    case (enc_state_q)
      ENC_PRIME: begin
        // Wait until the synchroniser holds a real sample, not its reset zero.
        if (sync_fill_q[1]) begin
          prev_d      = enc_sync_q;
          enc_state_d = ENC_TRACK;
        end
      end
      ENC_TRACK: begin
        prev_d = enc_sync_q;
        if (pos_cur == pos_prev + 2'd1) begin
          up_d = 1'b1;
          if (vol_q != VOL_MAX) vol_d = vol_q + 1'b1;
        end else if (pos_cur == pos_prev - 2'd1) begin
          dn_d = 1'b1;
          if (vol_q != '0) vol_d = vol_q - 1'b1;
        end else if (pos_cur != pos_prev) begin
          err_d = 1'b1;
        end
      end
      default: enc_state_d = ENC_PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbs_meta_q  <= '0;
      pbs_sync_q  <= '0;
      enc_meta_q  <= '0;
      enc_sync_q  <= '0;
      sync_fill_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
      level_q     <= '0;
      rise_q      <= '0;
      state_q     <= '0;
      enc_state_q <= ENC_PRIME;
      prev_q      <= '0;
      vol_q       <= VOL_RST;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pbs_meta_q  <= bus.pbs;
      pbs_sync_q  <= pbs_meta_q;
      enc_meta_q  <= bus.enc_ab;
      enc_sync_q  <= enc_meta_q;
      sync_fill_q <= sync_fill_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      level_q     <= level_d;
      rise_q      <= rise_d;
      state_q     <= state_d;
      enc_state_q <= enc_state_d;
      prev_q      <= prev_d;
      vol_q       <= vol_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      err_q       <= err_d;
    end
  end

`ifdef INPUT_HOLD_EN
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0]  hold_cnt_q [NUM_BTN];
  logic [HOLD_W-1:0]  hold_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] hold_q, hold_d;

  // Counter parks at HOLD_CYCLES so a long press fires once until release.
  always_comb begin
    hold_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_cnt_d[i] = '0;
      if (level_q[i]) begin
        hold_cnt_d[i] = (hold_cnt_q[i] == HOLD_TOP) ? hold_cnt_q[i] : hold_cnt_q[i] + 1'b1;
        hold_d[i]     = (hold_cnt_q[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) hold_cnt_q[i] <= '0;
      hold_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) hold_cnt_q[i] <= hold_cnt_d[i];
      hold_q <= hold_d;
    end
  end

  assign bus.btn_hold = hold_q;
`else
  assign bus.btn_hold = '0;
`endif

  assign bus.btn_level    = level_q;
  assign bus.btn_rise     = rise_q;
  assign bus.btn_state    = state_q;
  assign bus.volume       = vol_q;
  assign bus.vol_up       = up_q;
  assign bus.vol_dn       = dn_q;
  assign bus.enc_err      = err_q;
  assign bus.enc_tracking = (enc_state_q == ENC_TRACK);

endmodule

// File: tb/tb_team_06_input_ctrl.sv
// Bench for team_06_input_ctrl: sample-window reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_team_06_input_ctrl;
  localparam int         NUM_BTN     = 4;
  localparam int         DB_CYCLES   = 8;
  localparam int         VOL_W       = 4;
  localparam int         VOL_INIT    = 0;
  localparam int         HOLD_CYCLES = 32;
  localparam logic [3:0] TOGGLE_MASK = 4'b1110;
  localparam int         VOL_MAX     = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  team_06_input_ctrl_if #(.NUM_BTN(NUM_BTN), .VOL_W(VOL_W)) bus ();

  team_06_input_ctrl #(
    .NUM_BTN(NUM_BTN), .DB_CYCLES(DB_CYCLES), .TOGGLE_MASK(TOGGLE_MASK),
    .VOL_W(VOL_W), .VOL_INIT(VOL_INIT), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #20 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs sampled at each posedge since reset; index 0 is the newest sample.
  logic [3:0] pbs_hist[$];
  logic [1:0] enc_hist[$];
  int         cyc;
  int         rise_cyc[NUM_BTN];
  logic [3:0] exp_level = '0, exp_rise = '0, exp_state = '0, exp_hold = '0;
  int         exp_vol = VOL_INIT;
  logic       exp_up = 1'b0, exp_dn = 1'b0, exp_err = 1'b0;
  logic [3:0] old_level;
  logic [1:0] cur, prv;
  logic       all_diff;

  function automatic logic [1:0] cw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      pbs_hist = {};
      enc_hist = {};
      for (int j = 0; j < DB_CYCLES + 2; j++) begin
        pbs_hist.push_front(4'b0);
        enc_hist.push_front(2'b0);
      end
      for (int i = 0; i < NUM_BTN; i++) rise_cyc[i] = 0;
      exp_level = '0; exp_rise = '0; exp_state = '0; exp_hold = '0;
      exp_vol = VOL_INIT; exp_up = 1'b0; exp_dn = 1'b0; exp_err = 1'b0;
    end else begin
      cyc++;
      pbs_hist.push_front(bus.pbs);
      void'(pbs_hist.pop_back());
      enc_hist.push_front(bus.enc_ab);
      void'(enc_hist.pop_back());
      old_level = exp_level;
      exp_hold = '0; exp_up = 1'b0; exp_dn = 1'b0; exp_err = 1'b0;
      // A button flips once its last DB_CYCLES synchronised samples all disagree.
      for (int i = 0; i < NUM_BTN; i++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= DB_CYCLES + 1; j++)
          if (pbs_hist[j][i] == old_level[i]) all_diff = 1'b0;
        if (all_diff) exp_level[i] = ~old_level[i];
      end
      exp_rise  = exp_level & ~old_level;
      exp_state = (TOGGLE_MASK & (exp_state ^ exp_rise)) | (~TOGGLE_MASK & exp_level);
      for (int i = 0; i < NUM_BTN; i++) begin
`ifdef INPUT_HOLD_EN
        if (old_level[i] && (cyc - rise_cyc[i] == HOLD_CYCLES)) exp_hold[i] = 1'b1;
`endif
        if (exp_rise[i]) rise_cyc[i] = cyc;
      end
      if (cyc >= 4) begin
        cur = enc_hist[2];
        prv = enc_hist[3];
        if (cur == prv) begin
        end else if (cur == cw_next(prv)) begin
          exp_up = 1'b1;
          if (exp_vol < VOL_MAX) exp_vol++;
        end else if (prv == cw_next(cur)) begin
          exp_dn = 1'b1;
          if (exp_vol > 0) exp_vol--;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  int up_cnt = 0, dn_cnt = 0, err_cnt = 0, rise1_cnt = 0, hold_cnt = 0;

  always @(negedge clk) begin
    chk("btn_level", bus.btn_level, exp_level);
    chk("btn_rise",  bus.btn_rise,  exp_rise);
    chk("btn_state", bus.btn_state, exp_state);
    chk("btn_hold",  bus.btn_hold,  exp_hold);
    chk("volume",    bus.volume,    exp_vol);
    chk("vol_up",    bus.vol_up,    exp_up);
    chk("vol_dn",    bus.vol_dn,    exp_dn);
    chk("enc_err",   bus.enc_err,   exp_err);
    up_cnt    += int'(bus.vol_up);
    dn_cnt    += int'(bus.vol_dn);
    err_cnt   += int'(bus.enc_err);
    rise1_cnt += int'(bus.btn_rise[1]);
    hold_cnt  += int'(bus.btn_hold != '0);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_level(input int b, output int n);
    n = 0;
    while (bus.btn_level[b] !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  task automatic enc_steps(input logic [1:0] seq[4], input int count);
    for (int s = 0; s < count; s++) begin
      bus.enc_ab = seq[s % 4];
      tick(2);
    end
    tick(4);
  endtask

  logic [1:0] cw_seq[4]  = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] acw_seq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  int n;

  // ---------------- directed stimulus ----------------
  initial begin
    bus.pbs    = '0;
    bus.enc_ab = 2'b00;
    tick(3);
    chk("rst_volume_held", bus.volume, VOL_INIT);
    chk("rst_outputs_held",
        {bus.btn_level, bus.btn_rise, bus.btn_state, bus.btn_hold,
         bus.vol_up, bus.vol_dn, bus.enc_err}, 0);
    #1 rst_n = 1'b1;
    tick(4);
    chk("rst_volume_released", bus.volume, VOL_INIT);
    chk("rst_outputs_released",
        {bus.btn_level, bus.btn_rise, bus.btn_state, bus.btn_hold,
         bus.vol_up, bus.vol_dn, bus.enc_err}, 0);

    // 5-cycle glitch must not be accepted
    rise1_cnt = 0;
    bus.pbs[1] = 1'b1;
    tick(5);
    bus.pbs[1] = 1'b0;
    tick(15);
    chk("glitch_level", bus.btn_level[1], 0);
    chk("glitch_rise_count", rise1_cnt, 0);

    // clean press: level after 2 + DB_CYCLES cycles, 1-cycle rise, toggle on
    bus.pbs[1] = 1'b1;
    wait_level(1, n);
    chk("press_latency", n, 10);
    chk("press_rise_pulse", bus.btn_rise[1], 1);
    tick(1);
    chk("press_rise_end", bus.btn_rise[1], 0);
    chk("toggle_first", bus.btn_state[1], 1);
    bus.pbs[1] = 1'b0;
    tick(12);
    chk("toggle_hold_after_release", bus.btn_state[1], 1);
    bus.pbs[1] = 1'b1;
    tick(12);
    chk("toggle_second", bus.btn_state[1], 0);
    bus.pbs[1] = 1'b0;
    tick(12);

    // momentary button 0
    bus.pbs[0] = 1'b1;
    tick(12);
    chk("momentary_on", {bus.btn_level[0], bus.btn_state[0]}, 2'b11);
    bus.pbs[0] = 1'b0;
    tick(12);
    chk("momentary_off", {bus.btn_level[0], bus.btn_state[0]}, 2'b00);

    // 20 CW steps saturate at 15 with 20 pulses
    up_cnt = 0; dn_cnt = 0; err_cnt = 0;
    enc_steps(cw_seq, 20);
    chk("cw_volume", bus.volume, 15);
    chk("cw_up_pulses", up_cnt, 20);
    chk("cw_dn_pulses", dn_cnt, 0);

    // 00 -> 11 jump is illegal and leaves volume alone
    err_cnt = 0;
    bus.enc_ab = 2'b11;
    tick(4);
    chk("jump_00_11_err", err_cnt, 1);
    chk("jump_00_11_volume", bus.volume, 15);
    bus.enc_ab = 2'b00;
    tick(4);

    // 3 ACW steps from 00 -> volume 12, then 01 -> 10 jump
    dn_cnt = 0; err_cnt = 0;
    enc_steps(acw_seq, 3);
    chk("acw_volume", bus.volume, 12);
    chk("acw_dn_pulses", dn_cnt, 3);
    chk("acw_no_err", err_cnt, 0);
    bus.enc_ab = 2'b10;
    tick(4);
    chk("jump_01_10_err", err_cnt, 1);
    chk("jump_01_10_volume", bus.volume, 12);

    // reset at debounce count 6, encoder parked at 11 through release
    bus.pbs[1] = 1'b1;
    tick(8);
    #1 rst_n = 1'b0;
    bus.enc_ab = 2'b11;
    tick(1);
    chk("midreset_level", bus.btn_level[1], 0);
    chk("midreset_volume", bus.volume, VOL_INIT);
    tick(2);
    #1 rst_n = 1'b1;
    up_cnt = 0; dn_cnt = 0; err_cnt = 0;
    wait_level(1, n);
    chk("midreset_restart_latency", n, 10);
    tick(20);
    chk("prime_no_pulses", up_cnt + dn_cnt + err_cnt, 0);
    chk("prime_volume", bus.volume, VOL_INIT);

    // long press on button 2
    hold_cnt = 0;
    bus.pbs[2] = 1'b1;
    wait_level(2, n);
    chk("hold_btn_latency", n, 10);
`ifdef INPUT_HOLD_EN
    n = 0;
    while (bus.btn_hold[2] !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    chk("hold_pulse_delay", n, HOLD_CYCLES);
    tick(40);
    chk("hold_single_pulse", hold_cnt, 1);
`else
    tick(60);
    chk("hold_absent", hold_cnt, 0);
`endif
    bus.pbs[2] = 1'b0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
